// File: rtl/alu_pipe_n_if.sv
// rtl/alu_pipe_n_if.sv - request/result handshake bundle for alu_pipe_n
interface alu_pipe_n_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, result, cout, zero, neg, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, result, cout, zero, neg, ovf, busy
  );
endinterface

// File: rtl/alu_pipe_n.sv
// rtl/alu_pipe_n.sv - registered ALU with valid/ready handshakes and iterative multiply
module alu_pipe_n #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  alu_pipe_n_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_TRANSFER = 4'h0;
  localparam logic [3:0] OP_INC      = 4'h1;
  localparam logic [3:0] OP_ADD      = 4'h2;
  localparam logic [3:0] OP_ADDC     = 4'h3;
  localparam logic [3:0] OP_SUB      = 4'h4;
  localparam logic [3:0] OP_SUBB     = 4'h5;
  localparam logic [3:0] OP_DEC      = 4'h6;
  localparam logic [3:0] OP_PASS_B   = 4'h7;
  localparam logic [3:0] OP_OR       = 4'h8;
  localparam logic [3:0] OP_XOR      = 4'h9;
  localparam logic [3:0] OP_AND      = 4'hA;
  localparam logic [3:0] OP_NOT      = 4'hB;
  localparam logic [3:0] OP_SHL      = 4'hC;
  localparam logic [3:0] OP_SHR      = 4'hD;
  localparam logic [3:0] OP_MUL      = 4'hE;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic                 out_free, accept, start_mul, load_alu, load_mul;
  logic [WIDTH-1:0]     add_y;
  logic                 add_c, is_add;
  logic [WIDTH:0]       sum_w, shl_w, shr_w;
  logic [SHW-1:0]       amt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cout, alu_ovf;
  logic [2*WIDTH-1:0]   partial, acc_step;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_mul) state_d = MUL;
      MUL:     if (cnt_q == SHW'(WIDTH - 1)) state_d = DONE;
      DONE:    if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and handshake decode
  always_comb begin
    out_free  = !out_valid_q || bus.out_ready;
    bus.in_ready = (state_q == IDLE) && out_free;
    accept    = bus.in_valid && bus.in_ready;
    start_mul = accept && (bus.op == OP_MUL);
    load_alu  = accept && (bus.op != OP_MUL);
    load_mul  = (state_q == DONE) && out_free;
    bus.busy  = (state_q != IDLE);
  end

  // Single-cycle datapath: every add-family op shares one WIDTH+1 adder
  always_comb begin
    add_y  = '0;
    add_c  = 1'b0;
    is_add = 1'b0;
    case (bus.op)
      OP_INC:  begin is_add = 1'b1; add_c = 1'b1; end
      OP_ADD:  begin is_add = 1'b1; add_y = bus.b; end
      OP_ADDC: begin is_add = 1'b1; add_y = bus.b; add_c = bus.cin; end
      OP_SUB:  begin is_add = 1'b1; add_y = ~bus.b; add_c = 1'b1; end
      OP_SUBB: begin is_add = 1'b1; add_y = ~bus.b; add_c = bus.cin; end
      OP_DEC:  begin is_add = 1'b1; add_y = '1; end
      default: ;
    endcase
    sum_w = {1'b0, bus.a} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};
    amt   = bus.b[SHW-1:0];
    shl_w = {1'b0, bus.a} << amt;
    shr_w = {bus.a, 1'b0} >> amt;

    alu_res  = '0;
    alu_cout = 1'b0;
    case (bus.op)
      OP_TRANSFER: alu_res = bus.a;
      OP_INC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBB, OP_DEC: begin
        alu_res  = sum_w[WIDTH-1:0];
        alu_cout = sum_w[WIDTH];
      end
      OP_PASS_B: alu_res = bus.b;
      OP_OR:     alu_res = bus.a | bus.b;
      OP_XOR:    alu_res = bus.a ^ bus.b;
      OP_AND:    alu_res = bus.a & bus.b;
      OP_NOT:    alu_res = ~bus.a;
      // Extra guard bit catches the last bit shifted out; stays 0 for amount 0
      OP_SHL: begin alu_res = shl_w[WIDTH-1:0]; alu_cout = shl_w[WIDTH]; end
      OP_SHR: begin alu_res = shr_w[WIDTH:1];   alu_cout = shr_w[0];     end
      default: ;
    endcase
    alu_ovf = is_add && (bus.a[WIDTH-1] == add_y[WIDTH-1])
                     && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
  end

  // Result/flag and multiply register next-state
  always_comb begin
    partial  = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    acc_step = mplier_q[cnt_q] ? (acc_q + partial) : acc_q;

    result_d    = result_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.out_ready ? 1'b0 : out_valid_q;
    if (load_alu) begin
      result_d    = alu_res;
      cout_d      = alu_cout;
      ovf_d       = alu_ovf;
      zero_d      = (alu_res == '0);
      neg_d       = alu_res[WIDTH-1];
      out_valid_d = 1'b1;
    end else if (load_mul) begin
      result_d    = acc_q[WIDTH-1:0];
      cout_d      = |acc_q[2*WIDTH-1:WIDTH];
      ovf_d       = 1'b0;
      zero_d      = (acc_q[WIDTH-1:0] == '0);
      neg_d       = acc_q[WIDTH-1];
      out_valid_d = 1'b1;
    end

    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_mul) begin
      mcand_d  = bus.a;
      mplier_d = bus.b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == MUL) begin
      acc_d = acc_step;
      cnt_d = cnt_q + SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
endmodule
